// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, defaults and slot record for the sprite compositor.
package sprite_pkg;
  localparam int SIZE_DEF = 20;
  localparam int PX_W = 11;
  localparam int PY_W = 10;
  localparam int ADDR_W = 10;
  localparam int ELEM_MAX = 16;
  typedef struct packed {
    logic [PX_W-1:0] x;
    logic [PY_W-1:0] y;
    logic [ELEM_MAX-1:0] element;
    logic visible;
  } slot_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel stream, slot-write port and draw outputs of the sprite compositor.
interface sprite_compositor_if import sprite_pkg::*; #(parameter int ELEMENT = 5, parameter int SLOTS = 4);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  logic active;
  logic [PX_W-1:0] pixel_x;
  logic [PY_W-1:0] pixel_y;
  logic wr_en;
  logic [SW-1:0] wr_slot;
  logic [PX_W-1:0] wr_x;
  logic [PY_W-1:0] wr_y;
  logic [ELEMENT-1:0] wr_element;
  logic wr_visible;
  logic ready;
  logic [ELEMENT-1:0] element;
  logic [ADDR_W-1:0] address;
  logic collision;
  modport master (output active, pixel_x, pixel_y, wr_en, wr_slot, wr_x, wr_y, wr_element, wr_visible,
                  input ready, element, address, collision);
  modport slave (input active, pixel_x, pixel_y, wr_en, wr_slot, wr_x, wr_y, wr_element, wr_visible,
                 output ready, element, address, collision);
endinterface

// File: rtl/sprite_compositor_hit.sv
// sprite_hit: hit test and in-sprite pixel offset for one slot.
module sprite_hit import sprite_pkg::*; #(parameter int SIZE = SIZE_DEF) (
  input  logic [PX_W-1:0]   x_i,
  input  logic [PY_W-1:0]   y_i,
  input  logic              vis_i,
  input  logic [PX_W-1:0]   px_i,
  input  logic [PY_W-1:0]   py_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] offset_o
);
  localparam logic [PX_W:0] SX = (PX_W+1)'(SIZE);
  localparam logic [PY_W:0] SY = (PY_W+1)'(SIZE);
  logic [PX_W-1:0] dx;
  logic [PY_W-1:0] dy;
  // One extra bit keeps x+SIZE from wrapping near the right edge of the coordinate range
  always_comb begin
    dx = px_i - x_i;
    dy = py_i - y_i;
    hit_o = vis_i && {1'b0, px_i} >= {1'b0, x_i} && {1'b0, px_i} < {1'b0, x_i} + SX
                  && {1'b0, py_i} >= {1'b0, y_i} && {1'b0, py_i} < {1'b0, y_i} + SY;
    offset_o = ADDR_W'(32'(dy) * SIZE + 32'(dx));
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel sprite slot arbitration with frame-committed slot updates;
// define SPRITE_COLLISION_EN to build the sticky per-frame overlap flag.
module sprite_compositor import sprite_pkg::*; #(
  parameter int ELEMENT = 5,
  parameter int SLOTS = 4,
  parameter int SIZE = SIZE_DEF
) (
  input logic clk,
  input logic reset,
  sprite_compositor_if.slave bus
);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  slot_t shadow_q [SLOTS];
  slot_t shadow_d [SLOTS];
  slot_t live_q [SLOTS];
  slot_t live_d [SLOTS];
  logic [SLOTS-1:0] hit;
  logic [ADDR_W-1:0] offset [SLOTS];
  logic commit, ready_d, ready_q;
  logic [ELEMENT-1:0] element_d, element_q;
  logic [ADDR_W-1:0] address_d, address_q;
  assign commit = bus.pixel_x == '0 && bus.pixel_y == '0;
  // Commit takes the post-write shadow so a write on the commit cycle lands this frame
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      shadow_d[s] = bus.wr_en && bus.wr_slot == SW'(s)
                  ? slot_t'{x: bus.wr_x, y: bus.wr_y, element: ELEM_MAX'(bus.wr_element), visible: bus.wr_visible}
                  : shadow_q[s];
      live_d[s] = commit ? shadow_d[s] : live_q[s];
    end
  end
  for (genvar i = 0; i < SLOTS; i++) begin : g_hit
    sprite_hit #(.SIZE(SIZE)) u_hit (
      .x_i(live_q[i].x), .y_i(live_q[i].y), .vis_i(live_q[i].visible),
      .px_i(bus.pixel_x), .py_i(bus.pixel_y), .hit_o(hit[i]), .offset_o(offset[i])
    );
  end
  always_comb begin
    ready_d = 1'b0;
    element_d = '0;
    address_d = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (bus.active && hit[s]) begin
        ready_d = 1'b1;
        element_d = ELEMENT'(live_q[s].element);
        address_d = offset[s];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      live_q <= '{default: '0};
      ready_q <= 1'b0;
      element_q <= '0;
      address_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      live_q <= live_d;
      ready_q <= ready_d;
      element_q <= element_d;
      address_q <= address_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.element = element_q;
  assign bus.address = address_q;
`ifdef SPRITE_COLLISION_EN
  logic collision_d, collision_q;
  assign collision_d = (bus.active && (hit & (hit - SLOTS'(1))) != '0) || (collision_q && !commit);
  always_ff @(posedge clk) collision_q <= reset ? 1'b0 : collision_d;
  assign bus.collision = collision_q;
`else
  assign bus.collision = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed table, corner sequences and randomized model check of sprite_compositor.
module tb_sprite_compositor;
  localparam int SIZE = 20;
`ifdef SPRITE_COLLISION_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sprite_compositor_if #(.ELEMENT(5), .SLOTS(4)) bus();
  sprite_compositor #(.ELEMENT(5), .SLOTS(4), .SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0, fails = 0;
  int sx[4], sy[4], se[4], sv[4], lx[4], ly[4], le[4], lv[4];
  int m_coll = 0, e_rdy = 0, e_el = 0, e_ad = 0;
  typedef struct {
    bit we; int sl, x, y, el; bit vis, act; int px, py; int r, e, a;
  } vec_t;
  vec_t tbl[10];

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk3(string nm, int r, int e, int a);
    check({nm, ".ready"}, int'(bus.ready), r);
    check({nm, ".element"}, int'(bus.element), e);
    check({nm, ".address"}, int'(bus.address), a);
  endtask

  task automatic drive(bit we, int sl, int x, int y, int el, bit vis, bit act, int px, int py);
    bus.wr_en = we;
    bus.wr_slot = 2'(sl);
    bus.wr_x = 11'(x);
    bus.wr_y = 10'(y);
    bus.wr_element = 5'(el);
    bus.wr_visible = vis;
    bus.active = act;
    bus.pixel_x = 11'(px);
    bus.pixel_y = 10'(py);
  endtask

  // Reference: shadow/live slot tables, lowest-index winner, sticky overlap flag
  task automatic cyc();
    int px, py, n, w;
    bit cm;
    px = int'(bus.pixel_x);
    py = int'(bus.pixel_y);
    cm = (px == 0 && py == 0);
    n = 0;
    w = -1;
    for (int s = 0; s < 4; s++)
      if (lv[s] != 0 && px >= lx[s] && px < lx[s] + SIZE && py >= ly[s] && py < ly[s] + SIZE) begin
        n++;
        if (w < 0) w = s;
      end
    if (reset) begin
      e_rdy = 0; e_el = 0; e_ad = 0; m_coll = 0;
      for (int s = 0; s < 4; s++) begin
        sx[s] = 0; sy[s] = 0; se[s] = 0; sv[s] = 0;
        lx[s] = 0; ly[s] = 0; le[s] = 0; lv[s] = 0;
      end
    end else begin
      e_rdy = (bus.active && w >= 0) ? 1 : 0;
      e_el = e_rdy != 0 ? le[w] : 0;
      e_ad = e_rdy != 0 ? ((py - ly[w]) * SIZE + (px - lx[w])) % 1024 : 0;
      m_coll = (CE != 0 && ((bus.active && n >= 2) || (m_coll != 0 && !cm))) ? 1 : 0;
      if (bus.wr_en) begin
        sx[bus.wr_slot] = int'(bus.wr_x);
        sy[bus.wr_slot] = int'(bus.wr_y);
        se[bus.wr_slot] = int'(bus.wr_element);
        sv[bus.wr_slot] = int'(bus.wr_visible);
      end
      if (cm)
        for (int s = 0; s < 4; s++) begin
          lx[s] = sx[s]; ly[s] = sy[s]; le[s] = se[s]; lv[s] = sv[s];
        end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1, 0, 100, 50, 5, 1, 1, 500, 300, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 105, 53, 1, 5, 65};
    tbl[3] = '{1, 1, 110, 50, 2, 1, 1, 112, 50, 1, 5, 12};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 112, 50, 1, 5, 12};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 120, 50, 1, 2, 10};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 119, 69, 1, 5, 399};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 130, 50, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 105, 53, 0, 0, 0};
    drive(1, 0, 100, 50, 5, 1, 1, 105, 53);
    reset = 1'b1;
    cyc();
    cyc();
    chk3("reset", 0, 0, 0);
    check("reset.collision", int'(bus.collision), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].we, tbl[i].sl, tbl[i].x, tbl[i].y, tbl[i].el, tbl[i].vis, tbl[i].act, tbl[i].px, tbl[i].py);
      cyc();
      chk3($sformatf("tbl%0d", i), tbl[i].r, tbl[i].e, tbl[i].a);
    end
    check("overlap.collision", int'(bus.collision), CE);
    // Mid-frame move only takes effect at the next commit
    drive(1, 0, 300, 50, 5, 1, 1, 105, 53);
    cyc();
    chk3("move.same", 1, 5, 65);
    check("move.coll_held", int'(bus.collision), CE);
    drive(0, 0, 0, 0, 0, 0, 1, 105, 53);
    cyc();
    chk3("move.still", 1, 5, 65);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk3("move.commit", 0, 0, 0);
    check("move.coll_clear", int'(bus.collision), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 305, 53);
    cyc();
    chk3("move.new", 1, 5, 65);
    drive(0, 0, 0, 0, 0, 0, 1, 105, 53);
    cyc();
    chk3("move.old", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 320, 50);
    cyc();
    chk3("edge.right", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 319, 69);
    cyc();
    chk3("edge.corner", 1, 5, 399);
    drive(1, 2, 2040, 0, 7, 1, 0, 0, 0);
    cyc();
    chk3("wrap.commit", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0);
    cyc();
    chk3("wrap.none", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2045, 0);
    cyc();
    chk3("wrap.hit", 1, 7, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 305, 53);
    cyc();
    chk3("inactive", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 305, 53);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk3("midreset", 0, 0, 0);
    check("midreset.collision", int'(bus.collision), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 305, 53);
    cyc();
    chk3("postreset", 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int px, py, x, y;
      px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2000, 2047)) : int'($urandom_range(0, 260));
      py = int'($urandom_range(0, 140));
      if ($urandom_range(0, 39) == 0) begin px = 0; py = 0; end
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2030, 2047)) : int'($urandom_range(0, 240));
      y = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 120));
      drive(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), x, y, int'($urandom_range(0, 31)),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 5) != 0), px, py);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
      check("rnd.ready", int'(bus.ready), e_rdy);
      check("rnd.element", int'(bus.element), e_el);
      check("rnd.address", int'(bus.address), e_ad);
      check("rnd.collision", int'(bus.collision), m_coll);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
